burn_sequencer: RTL and testbench

BURN_SEQUENCER -- requirements
Module: burn_sequencer

---
 rtl/burn_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_burn_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burn_sequencer.sv
// burn_sequencer: steps a rocket-burn profile one simulated second at a time.
// A start latches the profile, and a one-cycle CHECK rejects invalid profiles.
// A 64-cycle restoring divider then computes the per-second mass loss. Each
// second the sequencer updates mass/elapsed and asks the shared thrust
// calculator for a velocity.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   start, abort      - begin a sequence / cancel back to idle (abort wins)
//   initial_weight, propellent_weight, burntime - profile, latched on start
//   calc_req, calc_mass        - request and mass presented to the calculator
//   calc_ack, calc_velocity    - calculator handshake and result
//   velocity, mass, elapsed    - last captured velocity, current mass, seconds
//   busy, done, err            - status
module burn_sequencer #(
   parameter int unsigned TICKS_PER_SEC = 1000,
   parameter int unsigned ACK_TIMEOUT   = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic [63:0]  initial_weight,
   input  logic [63:0]  propellent_weight,
   input  logic [63:0]  burntime,
   output logic         calc_req,
   output logic [63:0]  calc_mass,
   input  logic         calc_ack,
   input  logic [127:0] calc_velocity,
   output logic [127:0] velocity,
   output logic [63:0]  mass,
   output logic [63:0]  elapsed,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam int unsigned TICK_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int unsigned TO_W   = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_DIV   = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_REQ   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_FAULT = 3'd6;

   logic [2:0]        state;
   logic [2:0]        state_next;
   logic [63:0]       init_q;
   logic [63:0]       prop_q;
   logic [63:0]       bt_q;
   logic [63:0]       quot;        // dividend shifting out, quotient (rate) shifting in
   logic [63:0]       rem;
   logic [5:0]        div_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic [TO_W-1:0]   to_cnt;

   logic        tick_last;
   logic        to_last;
   logic        div_last;
   logic        profile_bad;
   logic [64:0] trial;
   logic        fits;
   logic [63:0] diff;
   logic [63:0] elapsed_inc;
   logic [63:0] mass_next;

   // Datapath helpers: divider step, counter terminals, next-second mass.
   always_comb begin
      tick_last   = (tick_cnt == TICK_W'(TICKS_PER_SEC - 1));
      to_last     = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
      div_last    = (div_cnt == 6'd63);
      profile_bad = (bt_q == 64'd0) || (prop_q > init_q);
      trial       = {rem, quot[63]};
      fits        = (trial >= {1'b0, bt_q});
      // When the divisor fits, trial < 2*divisor, so the low 64 bits suffice.
      diff        = trial[63:0] - bt_q;
      elapsed_inc = elapsed + 64'd1;
      // The final second absorbs the division remainder exactly.
      mass_next   = (elapsed_inc == bt_q) ? (init_q - prop_q) : (mass - quot);
   end

   // Next-state logic; abort overrides everything.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE, S_FAULT: if (start) state_next = S_CHECK;
         S_CHECK: state_next = profile_bad ? S_FAULT : S_DIV;
         S_DIV:   if (div_last) state_next = S_RUN;
         S_RUN:   if (tick_last) state_next = S_REQ;
         S_REQ: begin
            if (calc_ack)     state_next = (elapsed == bt_q) ? S_DONE : S_RUN;
            else if (to_last) state_next = S_FAULT;
         end
         default: state_next = S_IDLE;
      endcase
      if (abort) state_next = S_IDLE;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Status outputs registered from the next state so they align with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         calc_req <= 1'b0;
      end else begin
         busy     <= (state_next == S_CHECK) || (state_next == S_DIV) ||
                     (state_next == S_RUN)   || (state_next == S_REQ);
         done     <= (state_next == S_DONE);
         err      <= (state_next == S_FAULT);
         calc_req <= (state_next == S_REQ);
      end
   end

   // Datapath; frozen on abort so mass/elapsed/velocity are retained.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_q    <= '0;
         prop_q    <= '0;
         bt_q      <= '0;
         quot      <= '0;
         rem       <= '0;
         div_cnt   <= '0;
         tick_cnt  <= '0;
         to_cnt    <= '0;
         mass      <= '0;
         calc_mass <= '0;
         elapsed   <= '0;
         velocity  <= '0;
      end else if (!abort) begin
         case (state)
            S_IDLE, S_DONE, S_FAULT: begin
               if (start) begin
                  init_q    <= initial_weight;
                  prop_q    <= propellent_weight;
                  bt_q      <= burntime;
                  mass      <= initial_weight;
                  calc_mass <= initial_weight;
                  elapsed   <= '0;
                  velocity  <= '0;
               end
            end
            S_CHECK: begin
               quot    <= prop_q;
               rem     <= '0;
               div_cnt <= '0;
            end
            S_DIV: begin
               quot     <= {quot[62:0], fits};
               rem      <= fits ? diff : trial[63:0];
               div_cnt  <= div_cnt + 6'd1;
               tick_cnt <= '0;
            end
            S_RUN: begin
               tick_cnt <= tick_cnt + TICK_W'(1);
               if (tick_last) begin
                  elapsed   <= elapsed_inc;
                  mass      <= mass_next;
                  calc_mass <= mass_next;
                  to_cnt    <= '0;
               end
            end
            S_REQ: begin
               if (calc_ack) begin
                  velocity <= calc_velocity;
                  tick_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_burn_sequencer.sv
// Directed bench for burn_sequencer with a scoreboard of expected per-second
// mass/elapsed values pushed at start and popped on each calc_req.
module tb_burn_sequencer;

   localparam logic [63:0] VEL_TAG = 64'h0000_ABCD_0000_1234;

   typedef struct packed {
      logic [63:0] mass;
      logic [63:0] el;
   } exp_t;

   logic         clk;
   logic         reset;
   logic         start;
   logic         abort;
   logic [63:0]  initial_weight;
   logic [63:0]  propellent_weight;
   logic [63:0]  burntime;
   logic         calc_req;
   logic [63:0]  calc_mass;
   logic         calc_ack;
   logic [127:0] calc_velocity;
   logic [127:0] velocity;
   logic [63:0]  mass;
   logic [63:0]  elapsed;
   logic         busy;
   logic         done;
   logic         err;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   burn_sequencer #(.TICKS_PER_SEC(4), .ACK_TIMEOUT(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .abort            (abort),
      .initial_weight   (initial_weight),
      .propellent_weight(propellent_weight),
      .burntime         (burntime),
      .calc_req         (calc_req),
      .calc_mass        (calc_mass),
      .calc_ack         (calc_ack),
      .calc_velocity    (calc_velocity),
      .velocity         (velocity),
      .mass             (mass),
      .elapsed          (elapsed),
      .busy             (busy),
      .done             (done),
      .err              (err)
   );

   // Calculator result carries a tag plus the requested mass.
   assign calc_velocity = {VEL_TAG, calc_mass};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expd);
      checks++;
      assert (obs === expd) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
      end
   endtask

   // Full burn with calc_ack held high; scoreboard checks every request.
   task automatic run_burn(input logic [63:0] iw, input logic [63:0] pw, input logic [63:0] bt);
      logic [63:0] rate;
      logic [63:0] prev_mass;
      bit          have_prev;
      int          pulses;
      exp_t        e;
      rate = pw / bt;
      for (int k = 1; k <= int'(bt); k++) begin
         e.el   = 64'(k);
         e.mass = (64'(k) == bt) ? (iw - pw) : (iw - rate * 64'(k));
         exp_q.push_back(e);
      end
      initial_weight    = iw;
      propellent_weight = pw;
      burntime          = bt;
      calc_ack          = 1'b1;
      start             = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", 128'(busy), 128'(1));
      check("start_elapsed", 128'(elapsed), 128'(0));
      check("start_mass", 128'(mass), 128'(iw));
      pulses    = 0;
      have_prev = 0;
      prev_mass = '0;
      for (int c = 0; c < 4000 && !done; c++) begin
         if (calc_req) begin
            pulses++;
            check("req_velocity", velocity, have_prev ? {VEL_TAG, prev_mass} : 128'd0);
            if (exp_q.size() == 0) begin
               check("extra_req", 128'(pulses), 128'(bt));
            end else begin
               e = exp_q.pop_front();
               check("calc_mass", 128'(calc_mass), 128'(e.mass));
               check("req_elapsed", 128'(elapsed), 128'(e.el));
               prev_mass = e.mass;
               have_prev = 1;
            end
         end
         tick();
      end
      check("done", 128'(done), 128'(1));
      check("pulses", 128'(pulses), 128'(bt));
      check("queue_empty", 128'(exp_q.size()), 128'(0));
      check("final_elapsed", 128'(elapsed), 128'(bt));
      check("final_velocity", velocity, {VEL_TAG, iw - pw});
      check("done_busy", 128'(busy), 128'(0));
      exp_q.delete();
   endtask

   // Watchdog against a stuck run.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   got;
      int   n;
      exp_t e;

      reset             = 1'b1;
      start             = 1'b0;
      abort             = 1'b0;
      calc_ack          = 1'b0;
      initial_weight    = '0;
      propellent_weight = '0;
      burntime          = '0;
      #3;
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_calc_req", 128'(calc_req), 128'(0));
      check("rst_mass", 128'(mass), 128'(0));
      check("rst_velocity", velocity, 128'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Nominal burn.
      run_burn(64'd3233500, 64'd2077000, 64'd168);
      check("nominal_final_mass", 128'(mass), 128'(1156500));

      // Remainder absorbed in the last second: 7, 4, 0.
      run_burn(64'd10, 64'd10, 64'd3);
      check("rem_final_mass", 128'(mass), 128'(0));

      // Invalid profile: zero burntime.
      calc_ack          = 1'b0;
      initial_weight    = 64'd100;
      propellent_weight = 64'd10;
      burntime          = 64'd0;
      start             = 1'b1;
      tick();
      start = 1'b0;
      check("bt0_check_busy", 128'(busy), 128'(1));
      check("bt0_done_cleared", 128'(done), 128'(0));
      tick();
      check("bt0_err", 128'(err), 128'(1));
      check("bt0_busy", 128'(busy), 128'(0));
      check("bt0_calc_req", 128'(calc_req), 128'(0));

      // Invalid profile: propellent exceeds initial weight (start from FAULT).
      initial_weight    = 64'd4;
      propellent_weight = 64'd5;
      burntime          = 64'd2;
      start             = 1'b1;
      tick();
      start = 1'b0;
      check("heavy_err_cleared", 128'(err), 128'(0));
      tick();
      check("heavy_err", 128'(err), 128'(1));
      check("heavy_busy", 128'(busy), 128'(0));
      check("heavy_calc_req", 128'(calc_req), 128'(0));

      // Ack timeout.
      initial_weight    = 64'd100;
      propellent_weight = 64'd10;
      burntime          = 64'd5;
      e.mass = 64'd98;
      e.el   = 64'd1;
      exp_q.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
      got = 0;
      for (int c = 0; c < 200; c++) begin
         if (calc_req) begin
            got = 1;
            break;
         end
         tick();
      end
      check("to_req_seen", 128'(got), 128'(1));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("to_calc_mass", 128'(calc_mass), 128'(e.mass));
      end
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (!calc_req) break;
         n++;
         tick();
      end
      check("to_req_len", 128'(n), 128'(16));
      check("to_err", 128'(err), 128'(1));
      check("to_calc_req", 128'(calc_req), 128'(0));
      check("to_busy", 128'(busy), 128'(0));
      check("to_mass_held", 128'(calc_mass), 128'(98));

      // Abort at elapsed=3 together with start and ack.
      initial_weight    = 64'd1000;
      propellent_weight = 64'd100;
      burntime          = 64'd10;
      calc_ack          = 1'b1;
      start             = 1'b1;
      tick();
      start = 1'b0;
      got = 0;
      for (int c = 0; c < 400; c++) begin
         if (elapsed == 64'd3) begin
            got = 1;
            break;
         end
         tick();
      end
      check("ab_reach_el3", 128'(got), 128'(1));
      abort    = 1'b1;
      start    = 1'b1;
      burntime = 64'd99;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("ab_busy", 128'(busy), 128'(0));
      check("ab_calc_req", 128'(calc_req), 128'(0));
      check("ab_done", 128'(done), 128'(0));
      check("ab_elapsed", 128'(elapsed), 128'(3));
      check("ab_mass", 128'(mass), 128'(970));
      check("ab_velocity", velocity, {VEL_TAG, 64'd980});
      tick();
      tick();
      check("ab_idle_busy", 128'(busy), 128'(0));
      check("ab_idle_elapsed", 128'(elapsed), 128'(3));
      burntime = 64'd10;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("ab_restart_elapsed", 128'(elapsed), 128'(0));
      check("ab_restart_mass", 128'(mass), 128'(1000));
      check("ab_restart_velocity", velocity, 128'd0);
      check("ab_restart_busy", 128'(busy), 128'(1));

      // Async reset mid-DIV, between clock edges.
      abort = 1'b1;
      tick();
      abort             = 1'b0;
      initial_weight    = 64'd3233500;
      propellent_weight = 64'd2077000;
      burntime          = 64'd168;
      start             = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      check("rs_busy_before", 128'(busy), 128'(1));
      #3;
      reset = 1'b1;
      #1;
      check("rs_busy", 128'(busy), 128'(0));
      check("rs_mass", 128'(mass), 128'(0));
      check("rs_calc_mass", 128'(calc_mass), 128'(0));
      check("rs_elapsed", 128'(elapsed), 128'(0));
      check("rs_calc_req", 128'(calc_req), 128'(0));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (calc_req || busy) n++;
      end
      check("rs_stays_idle", 128'(n), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
